shared_ram_rr: RTL and testbench
================================

Name: shared_ram_rr

Overview:
- Multi-port shared data memory for the multicore processor. NUM_PORTS cores share one single-ported synchronous RAM.
- A round-robin arbiter grants one request per cycle.
- The winner's address, write enable and write data are registered before the memory access.
- Read data is broadcast one cycle later, with a per-port valid strobe.

Parameters:
- WIDTH, 12, data word width in bits.
- DEPTH, 256, number of words.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- NUM_PORTS, 4, number of requesting cores (>=2).
- IDX_WIDTH, $clog2(NUM_PORTS), width of the internal port index.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rstN  input  1  reset, asynchronous assert, active-low.
- req  input  NUM_PORTS  per-port access request.
- wrEn  input  NUM_PORTS  per-port write (1) / read (0) qualifier; meaningful only with req.
- addr  input  NUM_PORTS*ADDR_WIDTH  packed addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- dataIn  input  NUM_PORTS*WIDTH  packed write data; port i at [i*WIDTH +: WIDTH].
- gnt  output  NUM_PORTS  one-hot, combinational; the request of this port is captured at the coming posedge.
- rdValid  output  NUM_PORTS  one-hot registered; dataOut holds read data for this port.
- dataOut  output  WIDTH  broadcast read data; 0 when no rdValid bit is set.
- parityErr  output  1  read parity mismatch, qualified by rdValid; 0 when PARITY_EN is not defined.

Behaviour:
- Reset (rstN low, asynchronous):
  - priority pointer = 0; registered wrEn_reg, valid_reg, sel_reg, addr_reg, dataIn_reg = 0.
  - gnt forced 0; rdValid = 0; dataOut = 0; parityErr = 0.
  - Memory contents are not cleared.
- Arbitration (combinational):
  - Search req starting at index ptr, wrapping NUM_PORTS-1 -> 0. The first set bit wins and gnt[winner]=1. No req means gnt=0.
  - At most one gnt bit is set per cycle.
- Pointer update: on a posedge with a grant, ptr <= (winner+1) mod NUM_PORTS. With no grant, ptr holds.
- Capture, posedge ending cycle k with a grant:
  - sel_reg <= winner, addr_reg <= addr[winner], dataIn_reg <= dataIn[winner], wrEn_reg <= wrEn[winner], valid_reg <= 1.
  - With no grant, valid_reg <= 0 and wrEn_reg <= 0.
- Read, cycle k+1, when valid_reg=1 and wrEn_reg=0:
  - rdValid[sel_reg]=1 and dataOut = memory[addr_reg], combinational from registered address.
  - Read latency is 1 cycle after grant.
- Write, cycle k+1, when valid_reg=1 and wrEn_reg=1: memory[addr_reg] <= dataIn_reg at the posedge ending k+1. No rdValid is asserted.
- Requester handshake:
  - A port keeps req/addr/wrEn/dataIn stable until it sees gnt high at a posedge.
  - It may deassert or issue the next request in the following cycle. Back-to-back grants to the same port are allowed when it is the only requester.
- Read-after-write, same address, consecutive grants: the read returns the new data, because the write commits before the read cycle. There is no bypass logic.
- Write-after-read, consecutive grants: the read returns the old data.
- Starvation bound: a continuously requesting port is granted within NUM_PORTS cycles.
- Reset mid-operation: a captured but uncommitted write is discarded; an in-flight read produces no rdValid.
- Out-of-range address (DEPTH not a power of two): reads return 0 and writes are ignored.

Optional Feature:
- Macro PARITY_EN.
- Defined:
  - Memory is WIDTH+1 bits wide; bit WIDTH stores the even parity (XOR) of the data at write.
  - On a read cycle, parityErr = XOR of the stored word, including the parity bit; it is 0 when rdValid is all-zero.
- Not defined:
  - Memory is WIDTH bits wide and parityErr is tied 0.
  - No added logic; latency is identical in both builds.

Test Plan:
- Reset, then single port: port 2 writes 0xABC to addr 0x10, then reads 0x10.
  -> gnt=4'b0100 both requests; rdValid=4'b0100 one cycle after the read grant; dataOut=0xABC.
- All four ports request reads continuously from ptr=0.
  -> gnt sequence 0001, 0010, 0100, 1000, 0001; each rdValid follows its gnt by exactly 1 cycle.
- Port 0 writes 0x123 to addr 5 and port 1 reads addr 5 in the same cycle.
  -> port 0 granted first; port 1 granted next cycle; port 1 read returns 0x123.
- Port 3 writes 0x555 to addr 7; assert rstN low before the commit edge; release; read addr 7.
  -> old value returned; rdValid and dataOut are 0 during reset.
- Ports 1 and 3 request continuously after ptr is set to 2.
  -> grants alternate 3, 1, 3, 1; no port waits more than NUM_PORTS cycles.
- PARITY_EN: write 0x0F0 to addr 9, backdoor-flip data bit 0, read addr 9.
  -> parityErr=1 with rdValid. Without the flip -> parityErr=0.

Source files
------------

// File: rtl/shared_ram_rr.sv
// Shared single-ported RAM for NUM_PORTS cores with a round-robin arbiter and 1-cycle read latency.
// Optional build macro PARITY_EN adds a stored even-parity bit and a read parity-error flag.
module shared_ram_rr #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned IDX_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rstN,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            wrEn,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_PORTS*WIDTH-1:0]      dataIn,
  output logic [NUM_PORTS-1:0]            gnt,
  output logic [NUM_PORTS-1:0]            rdValid,
  output logic [WIDTH-1:0]                dataOut,
  output logic                            parityErr
);

`ifdef PARITY_EN
  localparam int unsigned MEM_WIDTH = WIDTH + 1;
`else
  localparam int unsigned MEM_WIDTH = WIDTH;
`endif

  logic [IDX_WIDTH-1:0]  ptr;
  logic [IDX_WIDTH-1:0]  ptr_next;
  logic [IDX_WIDTH-1:0]  win;
  logic                  any_gnt;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [WIDTH-1:0]      win_data;
  logic                  win_wr;
  int unsigned           idx;

  logic [IDX_WIDTH-1:0]  sel_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0]      data_in_reg;
  logic                  wr_en_reg;
  logic                  valid_reg;

  logic [MEM_WIDTH-1:0]  mem [DEPTH];
  logic [MEM_WIDTH-1:0]  wr_word;
  logic [MEM_WIDTH-1:0]  rd_word;
  logic                  in_range;
  logic                  rd_active;

  // Round-robin search starting at ptr; the first requester wins.
  always_comb begin
    any_gnt = 1'b0;
    win     = '0;
    idx     = 0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      idx = (int'(ptr) + i) % NUM_PORTS;
      if (!any_gnt && req[idx]) begin
        any_gnt = 1'b1;
        win     = IDX_WIDTH'(idx);
      end
    end
    if (!rstN) any_gnt = 1'b0;
    gnt = '0;
    if (any_gnt) gnt[win] = 1'b1;
    ptr_next = (win == IDX_WIDTH'(NUM_PORTS - 1)) ? '0 : IDX_WIDTH'(win + 1'b1);
    win_addr = addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
    win_data = dataIn[int'(win)*WIDTH +: WIDTH];
    win_wr   = wrEn[win];
  end

  // Arbitration pointer and captured request of the winner.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ptr         <= '0;
      sel_reg     <= '0;
      addr_reg    <= '0;
      data_in_reg <= '0;
      wr_en_reg   <= 1'b0;
      valid_reg   <= 1'b0;
    end else if (any_gnt) begin
      ptr         <= ptr_next;
      sel_reg     <= win;
      addr_reg    <= win_addr;
      data_in_reg <= win_data;
      wr_en_reg   <= win_wr;
      valid_reg   <= 1'b1;
    end else begin
      wr_en_reg   <= 1'b0;
      valid_reg   <= 1'b0;
    end
  end

  assign in_range  = ({1'b0, addr_reg} < (ADDR_WIDTH + 1)'(DEPTH));
  assign rd_active = valid_reg & ~wr_en_reg;

`ifdef PARITY_EN
  assign wr_word = {^data_in_reg, data_in_reg};
`else
  assign wr_word = data_in_reg;
`endif

  // Memory array is never reset; an async reset clears valid_reg so a pending write is dropped.
  always_ff @(posedge clk) begin
    if (valid_reg && wr_en_reg && in_range) mem[addr_reg] <= wr_word;
  end

  // Read is combinational from the registered address; no bypass of a same-cycle write.
  always_comb begin
    rd_word = in_range ? mem[addr_reg] : '0;
    rdValid = '0;
    if (rd_active) rdValid[sel_reg] = 1'b1;
    dataOut = (rd_active && in_range) ? rd_word[WIDTH-1:0] : '0;
`ifdef PARITY_EN
    parityErr = rd_active & in_range & (^rd_word);
`else
    parityErr = 1'b0;
`endif
  end

endmodule

// File: tb/tb_shared_ram_rr.sv
// Directed self-checking bench for shared_ram_rr: arbitration order, read latency, RAW, reset drop, parity.
module tb_shared_ram_rr;
  localparam int unsigned W  = 12;
  localparam int unsigned D  = 256;
  localparam int unsigned AW = 8;
  localparam int unsigned NP = 4;

  logic              clk = 1'b0;
  logic              rstN;
  logic [NP-1:0]     req, wrEn, gnt, rdValid;
  logic [NP*AW-1:0]  addr;
  logic [NP*W-1:0]   dataIn;
  logic [W-1:0]      dataOut;
  logic              parityErr;
  logic              par_exp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shared_ram_rr #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .NUM_PORTS(NP), .IDX_WIDTH(2)) dut (
    .clk(clk), .rstN(rstN), .req(req), .wrEn(wrEn), .addr(addr), .dataIn(dataIn),
    .gnt(gnt), .rdValid(rdValid), .dataOut(dataOut), .parityErr(parityErr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req = '0; wrEn = '0; addr = '0; dataIn = '0;
  endtask

  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
    req[p] = 1'b1;
    wrEn[p] = w;
    addr[p*AW +: AW] = a;
    dataIn[p*W +: W] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef PARITY_EN
    par_exp = 1'b1;
`else
    par_exp = 1'b0;
`endif
    // reset: grant forced off even with a request pending
    rstN = 1'b0;
    idle();
    set_port(0, 1'b0, 8'h00, 12'h000);
    #3;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rdvalid", 32'(rdValid), 32'h0);
    chk("rst_dataout", 32'(dataOut), 32'h0);
    chk("rst_parity", 32'(parityErr), 32'h0);
    step(); step();
    rstN = 1'b1;
    idle();

    // single port: port 2 writes then reads 0x10
    set_port(2, 1'b1, 8'h10, 12'hABC);
    #1 chk("t1_wr_gnt", 32'(gnt), 32'b0100);
    step(); idle();
    set_port(2, 1'b0, 8'h10, 12'h000);
    #1 chk("t1_rd_gnt", 32'(gnt), 32'b0100);
    chk("t1_wr_no_rdvalid", 32'(rdValid), 32'h0);
    step(); idle();
    #1 chk("t1_rdvalid", 32'(rdValid), 32'b0100);
    chk("t1_dataout", 32'(dataOut), 32'hABC);
    chk("t1_parity", 32'(parityErr), 32'h0);
    step();
    chk("t1_idle_rdvalid", 32'(rdValid), 32'h0);
    chk("t1_idle_dataout", 32'(dataOut), 32'h0);

    // ptr is 3: grant port 3 once to bring ptr back to 0
    set_port(3, 1'b0, 8'h10, 12'h000);
    #1 chk("t2_pre_gnt", 32'(gnt), 32'b1000);
    step(); idle();

    // all four ports read continuously from ptr=0
    for (int p = 0; p < int'(NP); p++) set_port(p, 1'b0, 8'h10, 12'h000);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t2_gnt", 32'(gnt), 32'(1) << (k % 4));
      chk("t2_rdvalid", 32'(rdValid), (k == 0) ? 32'b1000 : (32'(1) << ((k - 1) % 4)));
      chk("t2_dataout", 32'(dataOut), 32'hABC);
      step();
    end
    idle();
    #1 chk("t2_last_rdvalid", 32'(rdValid), 32'b0001);

    // ptr is 1: grant port 3 alone to reset ptr to 0
    set_port(3, 1'b0, 8'h10, 12'h000);
    #1 chk("t3_pre_gnt", 32'(gnt), 32'b1000);
    step(); idle();

    // port 0 writes 0x123 @5 while port 1 reads @5
    set_port(0, 1'b1, 8'h05, 12'h123);
    set_port(1, 1'b0, 8'h05, 12'h000);
    #1 chk("t3_gnt0", 32'(gnt), 32'b0001);
    chk("t3_pre_rdvalid", 32'(rdValid), 32'b1000);
    step();
    req[0] = 1'b0;
    wrEn[0] = 1'b0;
    #1 chk("t3_gnt1", 32'(gnt), 32'b0010);
    chk("t3_wr_rdvalid", 32'(rdValid), 32'h0);
    step(); idle();
    #1 chk("t3_raw_rdvalid", 32'(rdValid), 32'b0010);
    chk("t3_raw_data", 32'(dataOut), 32'h123);

    // reset drops an uncommitted write: old 0x0A7 survives at addr 7
    set_port(3, 1'b1, 8'h07, 12'h0A7);
    #1 chk("t4_old_gnt", 32'(gnt), 32'b1000);
    step(); idle();
    step();
    set_port(3, 1'b1, 8'h07, 12'h555);
    #1 chk("t4_new_gnt", 32'(gnt), 32'b1000);
    step(); idle();
    #1 rstN = 1'b0;
    set_port(0, 1'b0, 8'h07, 12'h000);
    #1 chk("t4_rst_gnt", 32'(gnt), 32'h0);
    chk("t4_rst_rdvalid", 32'(rdValid), 32'h0);
    chk("t4_rst_dataout", 32'(dataOut), 32'h0);
    step(); step();
    rstN = 1'b1;
    idle();
    set_port(3, 1'b0, 8'h07, 12'h000);
    #1 chk("t4_rd_gnt", 32'(gnt), 32'b1000);
    step(); idle();
    #1 chk("t4_rdvalid", 32'(rdValid), 32'b1000);
    chk("t4_old_data", 32'(dataOut), 32'h0A7);

    // ptr 0 -> grant port 1 alone so ptr becomes 2
    set_port(1, 1'b0, 8'h05, 12'h000);
    #1 chk("t5_pre_gnt", 32'(gnt), 32'b0010);
    step(); idle();

    // ports 1 and 3 request continuously from ptr=2: 3,1,3,1
    set_port(1, 1'b0, 8'h05, 12'h000);
    set_port(3, 1'b0, 8'h07, 12'h000);
    #1 chk("t5_pre_rdvalid", 32'(rdValid), 32'b0010);
    chk("t5_pre_data", 32'(dataOut), 32'h123);
    for (int k = 0; k < 4; k++) begin
      chk("t5_gnt", 32'(gnt), (k % 2 == 0) ? 32'b1000 : 32'b0010);
      if (k > 0) begin
        chk("t5_rdvalid", 32'(rdValid), (k % 2 == 1) ? 32'b1000 : 32'b0010);
        chk("t5_data", 32'(dataOut), (k % 2 == 1) ? 32'h0A7 : 32'h123);
      end
      step();
    end
    idle();
    #1 chk("t5_last_rdvalid", 32'(rdValid), 32'b0010);
    chk("t5_last_data", 32'(dataOut), 32'h123);

    // parity: clean read, then backdoor-flip data bit 0 and read again
    set_port(0, 1'b1, 8'h09, 12'h0F0);
    #1 chk("t6_wr_gnt", 32'(gnt), 32'b0001);
    step(); idle();
    step();
    set_port(0, 1'b0, 8'h09, 12'h000);
    #1 chk("t6_rd_gnt", 32'(gnt), 32'b0001);
    step(); idle();
    #1 chk("t6_clean_data", 32'(dataOut), 32'h0F0);
    chk("t6_clean_parity", 32'(parityErr), 32'h0);
    dut.mem[9][0] = ~dut.mem[9][0];
    set_port(0, 1'b0, 8'h09, 12'h000);
    step(); idle();
    #1 chk("t6_flip_rdvalid", 32'(rdValid), 32'b0001);
    chk("t6_flip_data", 32'(dataOut), 32'h0F1);
    chk("t6_flip_parity", 32'(parityErr), 32'(par_exp));
    step();
    chk("t6_idle_parity", 32'(parityErr), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
